// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared single-port memory arbiter for fetch and load/store ports
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              hlt,
  output logic              halted,
  output logic              busy,
  output logic              err,
  output logic              err_src
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_SAT   = {WW{1'b1}};
  localparam bit            TMO_EN     = (TIMEOUT != 0);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          in_svc;
  logic          tmo;
  logic          arb;
  logic          sel_f;
  logic          sel_d;

  // An access is in flight while in FETCH or DATA.
  assign in_svc = (state == FETCH) || (state == DATA);
  // Abort on the last allowed unacknowledged service cycle; an ack in that cycle wins.
  assign tmo    = TMO_EN && in_svc && !mem_ack && (wait_cnt == WAIT_LAST);
  // Arbitration happens when idle, on completion, or on abort; never while reset is held.
  assign arb    = rst && ((state == IDLE) || (in_svc && mem_ack) || tmo);
  // Data has priority unless fetch has waited out MAX_STARVE data wins; halt blocks fetch.
  assign sel_f  = if_req && !hlt && (!d_req || (starve_cnt == STARVE_MAX));
  assign sel_d  = d_req && !sel_f;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection at each arbitration edge; HALT is only left by reset.
  always_comb begin
    state_nxt = state;
    if (arb) begin
      if (sel_f)             state_nxt = FETCH;
      else if (sel_d)        state_nxt = DATA;
      else if (hlt && !d_req) state_nxt = HALT;
      else                   state_nxt = IDLE;
    end
  end

  // Handshake and status outputs decoded from state and the arbitration edge.
  always_comb begin
    if_gnt  = arb && sel_f;
    d_gnt   = arb && sel_d;
    mem_req = in_svc;
    busy    = in_svc;
    halted  = (state == HALT);
  end

  // Capture the granted request so the memory sees a stable payload for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (if_gnt) begin
      mem_addr <= if_addr;
      mem_we   <= 1'b0;
    end else if (d_gnt) begin
      mem_addr  <= d_addr;
      mem_we    <= d_we;
      mem_wdata <= d_wdata;
    end
  end

  // Return read data with a one-cycle valid pulse, or flag an aborted access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_rdata <= '0;
      d_valid  <= 1'b0;
      d_rdata  <= '0;
      err      <= 1'b0;
      err_src  <= 1'b0;
    end else begin
      if_valid <= (state == FETCH) && mem_ack;
      d_valid  <= (state == DATA) && mem_ack;
      err      <= tmo;
      if ((state == FETCH) && mem_ack) if_rdata <= mem_rdata;
      if ((state == DATA) && mem_ack && !mem_we) d_rdata <= mem_rdata;
      if (tmo) err_src <= (state == DATA);
    end
  end

  // Starvation counter tracks data wins while fetch waits; wait counter tracks unacked service cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if (arb) begin
        if (d_gnt && if_req) begin
          if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
        end else if (if_gnt || !if_req) begin
          starve_cnt <= '0;
        end
      end
      if (arb)
        wait_cnt <= '0;
      else if (in_svc && !mem_ack && (wait_cnt != WAIT_SAT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        hlt;
  logic        halted;
  logic        busy;
  logic        err;
  logic        err_src;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STARVE(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hlt(hlt), .halted(halted), .busy(busy), .err(err), .err_src(err_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_ival;
    logic [31:0] e_irdata;
    logic        e_dval;
    logic [31:0] e_drdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[17];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv_idle();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; hlt = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
    chk1({tag, "_d_gnt"}, d_gnt, 1'b0);
    chk1({tag, "_if_valid"}, if_valid, 1'b0);
    chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk1({tag, "_d_valid"}, d_valid, 1'b0);
    chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk1({tag, "_halted"}, halted, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_err_src"}, err_src, 1'b0);
  endtask

  // One access on the chosen port with ack withheld; ack_last acks on the final allowed cycle.
  task automatic run_tmo(input bit dport, input bit ack_last);
    string tag;
    tag = $sformatf("tmo_d%0d_a%0d", dport, ack_last);
    @(negedge clk);
    drv_idle();
    if (dport) begin d_req = 1'b1; d_addr = 32'h300; end
    else begin if_req = 1'b1; if_addr = 32'h80; end
    #1;
    chk1({tag, "_gnt"}, dport ? d_gnt : if_gnt, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drv_idle();
      if (ack_last && k == 16) begin mem_ack = 1'b1; mem_rdata = 32'h7777_0001; end
      #1;
      chk1($sformatf("%s_svc%0d_mreq", tag, k), mem_req, 1'b1);
      chk1($sformatf("%s_svc%0d_err", tag, k), err, 1'b0);
    end
    @(negedge clk);
    drv_idle();
    #1;
    chk1({tag, "_err"}, err, !ack_last);
    chk1({tag, "_mreq_after"}, mem_req, 1'b0);
    chk1({tag, "_valid"}, dport ? d_valid : if_valid, ack_last);
    if (!ack_last) chk1({tag, "_err_src"}, err_src, dport);
    else chk32({tag, "_d_rdata"}, d_rdata, 32'h7777_0001);
    @(negedge clk);
    #1;
    chk1({tag, "_err_clear"}, err, 1'b0);
  endtask

  bit pat[7];

  initial begin
    tbl[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_00A0,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_0000,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[2]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_0004,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b1};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_0008,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 32'h1111_0008, 1'b0, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1111_0008, 1'b0, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1111_0008, 1'b0, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_0100,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h1111_0008, 1'b0, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BAD_0040,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1111_0008, 1'b1, 32'hCAFE_0100, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0BAD_0040, 1'b0, 32'hCAFE_0100, 1'b0};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0BAD_0040, 1'b0, 32'hCAFE_0100, 1'b0};
    for (int i = 11; i <= 14; i++)
      tbl[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, (i == 14), 32'h1234_5678,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0BAD_0040, 1'b0, 32'hCAFE_0100, 1'b1};
    tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0BAD_0040, 1'b1, 32'hCAFE_0100, 1'b0};
    tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0BAD_0040, 1'b0, 32'hCAFE_0100, 1'b0};

    // reset state
    rst = 1'b0;
    drv_idle();
    #12;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;

    // table: fetch stream, fetch/load contention, store with wait states
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drv_idle();
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      #1;
      chk1($sformatf("v%0d_if_gnt", i), if_gnt, tbl[i].e_igt);
      chk1($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].e_dgt);
      chk1($sformatf("v%0d_mem_req", i), mem_req, tbl[i].e_mreq);
      chk1($sformatf("v%0d_mem_we", i), mem_we, tbl[i].e_mwe);
      chk32($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_maddr);
      chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_mwdata);
      chk1($sformatf("v%0d_if_valid", i), if_valid, tbl[i].e_ival);
      chk32($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_irdata);
      chk1($sformatf("v%0d_d_valid", i), d_valid, tbl[i].e_dval);
      chk32($sformatf("v%0d_d_rdata", i), d_rdata, tbl[i].e_drdata);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
    end

    // starvation: four data wins, one forced fetch, then data again
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drv_idle();
      if_req = 1'b1; if_addr = 32'h500;
      d_req = 1'b1; d_addr = 32'h600 + 32'(k);
      mem_ack = 1'b1;
      #1;
      chk1($sformatf("starve%0d_d_gnt", k), d_gnt, pat[k]);
      chk1($sformatf("starve%0d_if_gnt", k), if_gnt, !pat[k]);
    end
    @(negedge clk);
    drv_idle();
    mem_ack = 1'b1;
    @(negedge clk);
    drv_idle();
    #1;
    chk1("starve_end_busy", busy, 1'b0);

    // timeouts: fetch abort, data ack on the last cycle, data abort
    run_tmo(1'b0, 1'b0);
    run_tmo(1'b1, 1'b1);
    run_tmo(1'b1, 1'b0);

    // halt during a fetch with two wait states
    @(negedge clk);
    drv_idle();
    if_req = 1'b1; if_addr = 32'hC0;
    #1;
    chk1("hlt_c0_if_gnt", if_gnt, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drv_idle();
      if_req = 1'b1; if_addr = 32'hC4; hlt = 1'b1;
      if (k == 3) begin mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA; end
      #1;
      chk1($sformatf("hlt_c%0d_if_gnt", k), if_gnt, 1'b0);
      chk1($sformatf("hlt_c%0d_mem_req", k), mem_req, 1'b1);
      chk1($sformatf("hlt_c%0d_halted", k), halted, 1'b0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk1("hlt_c4_halted", halted, 1'b1);
    chk1("hlt_c4_if_valid", if_valid, 1'b1);
    chk32("hlt_c4_if_rdata", if_rdata, 32'h55AA_55AA);
    chk1("hlt_c4_mem_req", mem_req, 1'b0);
    chk1("hlt_c4_busy", busy, 1'b0);
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h700;
    #1;
    chk1("hlt_c5_d_gnt", d_gnt, 1'b0);
    chk1("hlt_c5_if_gnt", if_gnt, 1'b0);
    chk1("hlt_c5_halted", halted, 1'b1);
    chk1("hlt_c5_if_valid", if_valid, 1'b0);
    rst = 1'b0;
    #1;
    check_reset("rst_hlt");

    // reset asserted mid-access discards it
    @(negedge clk);
    drv_idle();
    rst = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk1("abandon_if_gnt", if_gnt, 1'b1);
    @(negedge clk);
    drv_idle();
    #1;
    chk1("abandon_mem_req_pre", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1("abandon_mem_req_rst", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    drv_idle();
    #1;
    chk1("abandon_if_valid", if_valid, 1'b0);
    chk1("abandon_err", err, 1'b0);
    chk1("abandon_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
